// File: rtl/spk_osc_supervisor.sv
// Purpose: supervises the fast spike ring oscillator, counts its edges per window, kicks a stalled loop and latches a fault on repeated failed restarts.
// Latency: osc_tog edges are counted 3 sysClk cycles after they occur; status outputs are registered and update on the window's terminal cycle.
// Backpressure: none; free-running monitor. Optional frequency bounds are built when SPK_OSC_FREQ_LIMIT_EN is defined.
module spk_osc_supervisor #(
    parameter int WIN_W      = 8,
    parameter int CNT_W      = 8,
    parameter int KICK_CYC   = 4,
    parameter int SETTLE_CYC = 16,
    parameter int MAX_RETRY  = 3,
    parameter int RST_CNT_W  = 8
) (
    input  logic                 sysClk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 osc_tog,
    input  logic                 clear_fault,
`ifdef SPK_OSC_FREQ_LIMIT_EN
    input  logic [CNT_W-1:0]     freq_min,
    input  logic [CNT_W-1:0]     freq_max,
`endif
    output logic                 kick,
    output logic                 osc_ok,
    output logic                 fault,
    output logic [CNT_W-1:0]     freq_count,
    output logic [RST_CNT_W-1:0] restart_count,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_KICK    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [7:0] KICK_LAST   = 8'(KICK_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] RETRY_MAX   = 4'(MAX_RETRY);

    state_t               state;
    logic [2:0]           sync_q;
    logic                 tog_edge;
    logic [WIN_W-1:0]     win_cnt;
    logic                 win_last;
    logic [CNT_W-1:0]     edge_cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CNT_W-1:0]     win_total;
    logic                 win_healthy;
    logic [7:0]           timer;
    logic [3:0]           retry;
    logic [RST_CNT_W-1:0] restart_inc;

    // Two-flop synchroniser plus one history flop; either toggle direction is an edge.
    always_ff @(posedge sysClk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], osc_tog};
        end
    end

    assign tog_edge = sync_q[2] ^ sync_q[1];

    // Saturating edge accumulation; the terminal cycle's edge is folded into the window total.
    always_comb begin
        cnt_inc     = (&edge_cnt) ? edge_cnt : edge_cnt + 1'b1;
        win_total   = tog_edge ? cnt_inc : edge_cnt;
        win_last    = &win_cnt;
        restart_inc = (&restart_count) ? restart_count : restart_count + 1'b1;
`ifdef SPK_OSC_FREQ_LIMIT_EN
        win_healthy = (win_total != '0) && (win_total >= freq_min) && (win_total <= freq_max);
`else
        win_healthy = (win_total != '0);
`endif
    end

    // Supervisor FSM with all status outputs registered alongside the state.
    always_ff @(posedge sysClk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            win_cnt       <= '0;
            edge_cnt      <= '0;
            timer         <= 8'd0;
            retry         <= 4'd0;
            kick          <= 1'b0;
            osc_ok        <= 1'b0;
            fault         <= 1'b0;
            freq_count    <= '0;
            restart_count <= '0;
        end else if (!enable) begin
            // Disabling discards any partial window; retry survives only a FAULT exit so
            // re-enabling a faulted block escalates again on the first dead window.
            state    <= ST_IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            timer    <= 8'd0;
            kick     <= 1'b0;
            osc_ok   <= 1'b0;
            if (state != ST_FAULT) begin
                retry <= 4'd0;
            end
            if (clear_fault) begin
                fault <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_MEASURE;
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    if (clear_fault) begin
                        fault <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    win_cnt <= win_cnt + 1'b1;
                    if (win_last) begin
                        freq_count <= win_total;
                        edge_cnt   <= '0;
                        if (win_healthy) begin
                            osc_ok <= 1'b1;
                            retry  <= 4'd0;
                        end else if (retry < RETRY_MAX) begin
                            osc_ok        <= 1'b0;
                            retry         <= retry + 4'd1;
                            restart_count <= restart_inc;
                            kick          <= 1'b1;
                            timer         <= 8'd0;
                            state         <= ST_KICK;
                        end else begin
                            osc_ok <= 1'b0;
                            fault  <= 1'b1;
                            state  <= ST_FAULT;
                        end
                    end else begin
                        edge_cnt <= win_total;
                    end
                end
                ST_KICK: begin
                    edge_cnt <= '0;
                    if (timer == KICK_LAST) begin
                        kick  <= 1'b0;
                        timer <= 8'd0;
                        state <= ST_SETTLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    // Edges right after a kick are restart transients, not evidence of health.
                    edge_cnt <= '0;
                    if (timer == SETTLE_LAST) begin
                        timer   <= 8'd0;
                        win_cnt <= '0;
                        state   <= ST_MEASURE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_FAULT: begin
                    kick   <= 1'b0;
                    osc_ok <= 1'b0;
                    if (clear_fault) begin
                        fault    <= 1'b0;
                        retry    <= 4'd0;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                        state    <= ST_MEASURE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_spk_osc_supervisor.sv
// Directed bench for spk_osc_supervisor: table-driven main sequence plus hand-written
// sequences for the terminal-cycle edge, counter saturation, frequency bounds and async reset.
module tb_spk_osc_supervisor;

    logic       sys_clk;
    logic       reset_n;
    logic       enable;
    logic       osc_tog;
    logic       clear_fault;
    logic       kick;
    logic       osc_ok;
    logic       fault;
    logic [7:0] freq_count;
    logic [7:0] restart_count;
    logic [2:0] state_dbg;

    logic       en_sat;
    logic       osc_tog2;
    logic       clr_sat;
    logic       kick_s;
    logic       osc_ok_s;
    logic       fault_s;
    logic [2:0] freq_s;
    logic [7:0] restart_s;
    logic [2:0] state_s;

    logic [7:0] fmin;
    logic [7:0] fmax;
    logic [2:0] fmin_sat;
    logic [2:0] fmax_sat;

    logic       tog_mode;
    logic       ph;

    int n_cmp;
    int n_bad;

    spk_osc_supervisor #(.WIN_W(4), .CNT_W(8), .MAX_RETRY(2)) dut (
        .sysClk       (sys_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .osc_tog      (osc_tog),
        .clear_fault  (clear_fault),
`ifdef SPK_OSC_FREQ_LIMIT_EN
        .freq_min     (fmin),
        .freq_max     (fmax),
`endif
        .kick         (kick),
        .osc_ok       (osc_ok),
        .fault        (fault),
        .freq_count   (freq_count),
        .restart_count(restart_count),
        .state_dbg    (state_dbg)
    );

    spk_osc_supervisor #(.WIN_W(4), .CNT_W(3)) dut_sat (
        .sysClk       (sys_clk),
        .reset_n      (reset_n),
        .enable       (en_sat),
        .osc_tog      (osc_tog2),
        .clear_fault  (clr_sat),
`ifdef SPK_OSC_FREQ_LIMIT_EN
        .freq_min     (fmin_sat),
        .freq_max     (fmax_sat),
`endif
        .kick         (kick_s),
        .osc_ok       (osc_ok_s),
        .fault        (fault_s),
        .freq_count   (freq_s),
        .restart_count(restart_s),
        .state_dbg    (state_s)
    );

    typedef struct {
        logic       en;
        logic       clr;
        logic       tm;
        int         n;
        logic       cf;
        logic [2:0] st;
        logic       k;
        logic       ok;
        logic       f;
        logic [7:0] fr;
        logic [7:0] rs;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic en, input logic clr, input logic tm, input int n,
                                input logic cf, input logic [2:0] st, input logic k,
                                input logic ok, input logic f, input logic [7:0] fr,
                                input logic [7:0] rs);
        vec_t v;
        v.en = en; v.clr = clr; v.tm = tm; v.n = n; v.cf = cf; v.st = st;
        v.k = k; v.ok = ok; v.f = f; v.fr = fr; v.rs = rs;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // osc_tog flips every 2 cycles while tog_mode is set.
    initial begin
        osc_tog = 1'b0;
        ph      = 1'b0;
        forever begin
            @(posedge sys_clk);
            #2;
            if (tog_mode) begin
                ph = ~ph;
                if (ph) osc_tog = ~osc_tog;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 1'b0; enable = 1'b0; clear_fault = 1'b0; tog_mode = 1'b1;
        en_sat = 1'b0; osc_tog2 = 1'b0; clr_sat = 1'b0;
        fmin = 8'd1; fmax = 8'd255; fmin_sat = 3'd1; fmax_sat = 3'd7;

        //            en clr tm   n cf st k ok f fr rs
        tbl[0]  = mk(0, 0, 1,  3, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 17, 1, 1, 0, 1, 0, 8, 0);
        tbl[2]  = mk(1, 0, 1, 16, 1, 1, 0, 1, 0, 8, 0);
        tbl[3]  = mk(1, 0, 1,  8, 1, 1, 0, 1, 0, 8, 0);
        tbl[4]  = mk(1, 0, 0,  8, 0, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 16, 1, 2, 1, 0, 0, 0, 1);
        tbl[6]  = mk(1, 0, 0,  3, 1, 2, 1, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0,  1, 1, 3, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 15, 1, 3, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 16, 1, 2, 1, 0, 0, 0, 2);
        tbl[11] = mk(1, 0, 0,  4, 1, 3, 0, 0, 0, 0, 2);
        tbl[12] = mk(1, 0, 0, 16, 1, 1, 0, 0, 0, 0, 2);
        tbl[13] = mk(1, 0, 0, 16, 1, 4, 0, 0, 1, 0, 2);
        tbl[14] = mk(1, 0, 0,  4, 1, 4, 0, 0, 1, 0, 2);
        tbl[15] = mk(1, 1, 0,  1, 1, 1, 0, 0, 0, 0, 2);
        tbl[16] = mk(1, 0, 0, 16, 1, 2, 1, 0, 0, 0, 3);
        tbl[17] = mk(1, 0, 0,  1, 1, 2, 1, 0, 0, 0, 3);
        tbl[18] = mk(0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 3);
        tbl[19] = mk(0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 3);
        tbl[20] = mk(1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 3);
        tbl[21] = mk(1, 0, 0, 16, 1, 2, 1, 0, 0, 0, 4);
        tbl[22] = mk(1, 0, 0,  4, 1, 3, 0, 0, 0, 0, 4);
        tbl[23] = mk(1, 0, 0, 16, 1, 1, 0, 0, 0, 0, 4);
        tbl[24] = mk(1, 0, 0, 16, 1, 2, 1, 0, 0, 0, 5);
        tbl[25] = mk(1, 0, 0, 20, 1, 1, 0, 0, 0, 0, 5);
        tbl[26] = mk(1, 0, 0, 16, 1, 4, 0, 0, 1, 0, 5);
        tbl[27] = mk(0, 1, 0,  1, 1, 0, 0, 0, 0, 0, 5);
        tbl[28] = mk(0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 5);
        tbl[29] = mk(1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 5);

        // Reset state
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst.kick",    kick,          0);
        chk("rst.osc_ok",  osc_ok,        0);
        chk("rst.fault",   fault,         0);
        chk("rst.freq",    freq_count,    0);
        chk("rst.restart", restart_count, 0);
        chk("rst.state",   state_dbg,     0);
        chk("rst.sat_freq", freq_s,       0);
        reset_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);

        // Main table: inputs applied at a negedge, outputs checked n posedges later.
        for (int i = 0; i < 30; i++) begin
            enable      = tbl[i].en;
            clear_fault = tbl[i].clr;
            tog_mode    = tbl[i].tm;
            repeat (tbl[i].n) @(posedge sys_clk);
            @(negedge sys_clk);
            chk($sformatf("v%0d.state", i),   state_dbg,     tbl[i].st);
            chk($sformatf("v%0d.kick", i),    kick,          tbl[i].k);
            chk($sformatf("v%0d.osc_ok", i),  osc_ok,        tbl[i].ok);
            chk($sformatf("v%0d.fault", i),   fault,         tbl[i].f);
            chk($sformatf("v%0d.restart", i), restart_count, tbl[i].rs);
            if (tbl[i].cf) chk($sformatf("v%0d.freq", i), freq_count, tbl[i].fr);
        end
        clear_fault = 1'b0;

        // Single edge landing on the terminal cycle of the first window is counted.
        en_sat = 1'b1;
        repeat (14) @(posedge sys_clk);
        #2 osc_tog2 = ~osc_tog2;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("term.freq",   freq_s,   1);
        chk("term.osc_ok", osc_ok_s, 1);
        chk("term.state",  state_s,  1);

        // Toggle every cycle: 13 edges in a 3-bit counter saturate at 7.
        for (int j = 0; j < 16; j++) begin
            @(posedge sys_clk);
            #2 osc_tog2 = ~osc_tog2;
        end
        @(negedge sys_clk);
        chk("sat.freq",   freq_s,   7);
        chk("sat.osc_ok", osc_ok_s, 1);
        chk("sat.kick",   kick_s,   0);

        // Next window only sees 3 pipelined edges; with a lower bound of 4 it counts as dead.
        fmin_sat = 3'd4;
        repeat (16) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("lim.freq", freq_s, 3);
`ifdef SPK_OSC_FREQ_LIMIT_EN
        chk("lim.state",   state_s,   2);
        chk("lim.osc_ok",  osc_ok_s,  0);
        chk("lim.kick",    kick_s,    1);
        chk("lim.restart", restart_s, 1);
`else
        chk("lim.state",   state_s,   1);
        chk("lim.osc_ok",  osc_ok_s,  1);
        chk("lim.kick",    kick_s,    0);
        chk("lim.restart", restart_s, 0);
`endif

        // Asynchronous reset between clock edges clears everything immediately.
        @(posedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("areset.kick",     kick,          0);
        chk("areset.osc_ok",   osc_ok,        0);
        chk("areset.fault",    fault,         0);
        chk("areset.restart",  restart_count, 0);
        chk("areset.state",    state_dbg,     0);
        chk("areset.sat_freq", freq_s,        0);
        chk("areset.sat_kick", kick_s,        0);
        chk("areset.sat_ok",   osc_ok_s,      0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
